md_unit: RTL

Parametrised memory-data unit, successor to the basic MDR: holds the memory data register and runs the memory read/write transaction itself. Loads from the CPU bus, or from memory through a ready-handshake FSM with timeout. Supports byte/half/word access with lane alignment, sign/zero extension and byte enables. Sits between the datapath bus and the memory port; the control unit issues one request and waits for done.

---
 rtl/md_pkg.sv | 14 +
 rtl/md_if.sv | 9 +
 rtl/md_lane_align.sv | 27 ++
 rtl/md_unit.sv | 81 ++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: access-size and FSM encodings plus width helpers shared by the md_unit blocks.
package md_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_e;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_e;
  function automatic int lanes(int ws);
    return ws / 8;
  endfunction
  function automatic int off_w(int ws);
    return $clog2(ws / 8);
  endfunction
  function automatic logic aligned(size_e s, logic [2:0] off);
    return s == SZ_BYTE || (s == SZ_HALF && !off[0]) || (s == SZ_WORD && off == 3'd0);
  endfunction
endpackage

// File: rtl/md_if.sv
// md_if: memory port between md_unit (master) and the memory (slave).
interface md_if #(parameter int WORD_SIZE = 32, parameter int ADDR_WIDTH = 9);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_rd, mem_wr, mem_ready;
  logic [WORD_SIZE-1:0] mem_wdata, Mdatain;
  logic [WORD_SIZE/8-1:0] mem_be;
  modport master(output mem_addr, mem_rd, mem_wr, mem_wdata, mem_be, input Mdatain, mem_ready);
  modport slave(input mem_addr, mem_rd, mem_wr, mem_wdata, mem_be, output Mdatain, mem_ready);
endinterface

// File: rtl/md_lane_align.sv
// md_lane_align: read lane extract/extend, write lane shift and byte-enable generation.
module md_lane_align import md_pkg::*; #(parameter int WORD_SIZE = 32) (
  input  size_e size,
  input  logic sext,
  input  logic [off_w(WORD_SIZE)-1:0] off,
  input  logic [WORD_SIZE-1:0] rdata,
  input  logic [WORD_SIZE-1:0] wsrc,
  output logic [WORD_SIZE-1:0] rext,
  output logic [WORD_SIZE-1:0] wdata,
  output logic [lanes(WORD_SIZE)-1:0] be
);
  logic [WORD_SIZE-1:0] ones_w, mask, lane;
  logic [lanes(WORD_SIZE)-1:0] ones_l, base;
  logic sign;
  // one mask serves both zero/sign extension and clearing unused write bytes
  always_comb begin
    ones_w = '1;
    ones_l = '1;
    mask = size == SZ_WORD ? ones_w : ~(ones_w << (size == SZ_HALF ? 16 : 8));
    base = size == SZ_WORD ? ones_l : ~(ones_l << (size == SZ_HALF ? 2 : 1));
    lane = rdata >> {off, 3'b000};
    sign = sext && size != SZ_WORD && (size == SZ_HALF ? lane[15] : lane[7]);
    rext = sign ? (lane | ~mask) : (lane & mask);
    wdata = (wsrc & mask) << {off, 3'b000};
    be = base << off;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: memory data register that runs its own read/write transaction with timeout.
module md_unit import md_pkg::*; #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic MDRin,
  input  logic [WORD_SIZE-1:0] BusMuxOut,
  input  logic rd_req,
  input  logic wr_req,
  input  logic [1:0] size,
  input  logic sext,
  input  logic [ADDR_WIDTH-1:0] mar_in,
  output logic [WORD_SIZE-1:0] Q,
  output logic busy,
  output logic done,
  output logic err,
  md_if.master mem
);
  localparam int OW = off_w(WORD_SIZE);
  localparam int CW = $clog2(TIMEOUT);
  state_e st, nxt;
  size_e sz_q, al_size;
  logic sx_q, req, ok, waiting, tmo, fin;
  logic [OW-1:0] off, off_q, al_off;
  logic [CW-1:0] cnt;
  logic [WORD_SIZE-1:0] al_rext, al_wdata;
  logic [WORD_SIZE/8-1:0] al_be;
  md_lane_align #(.WORD_SIZE(WORD_SIZE)) u_align (
    .size(al_size), .sext(sx_q), .off(al_off), .rdata(mem.Mdatain), .wsrc(Q),
    .rext(al_rext), .wdata(al_wdata), .be(al_be)
  );
  assign busy = st != IDLE;
  assign done = st == DONE;
  // write lanes come from the live request; read lanes from what was latched
  always_comb begin
    off = mar_in[OW-1:0];
    req = st == IDLE && (rd_req || wr_req);
    ok = aligned(size_e'(size), 3'(off));
    waiting = st == RD_WAIT || st == WR_WAIT;
    tmo = cnt == CW'(TIMEOUT - 1);
    fin = waiting && (mem.mem_ready || tmo);
    nxt = req ? (!ok ? DONE : rd_req ? RD_WAIT : WR_WAIT) : st == DONE ? IDLE : fin ? DONE : st;
    al_size = st == IDLE ? size_e'(size) : sz_q;
    al_off = st == IDLE ? off : off_q;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st <= IDLE;
      cnt <= '0;
      Q <= '0;
      err <= 1'b0;
      sz_q <= SZ_BYTE;
      sx_q <= 1'b0;
      off_q <= '0;
      mem.mem_addr <= '0;
      mem.mem_rd <= 1'b0;
      mem.mem_wr <= 1'b0;
      mem.mem_wdata <= '0;
      mem.mem_be <= '0;
    end else begin
      st <= nxt;
      cnt <= waiting && !fin ? cnt + 1'b1 : '0;
      err <= (req && !ok) || (waiting && !mem.mem_ready && tmo);
      Q <= st == RD_WAIT && mem.mem_ready ? al_rext :
           st == IDLE && !rd_req && !wr_req && MDRin ? BusMuxOut : Q;
      if (req && ok) begin
        mem.mem_addr <= {mar_in[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        sz_q <= size_e'(size);
        sx_q <= sext;
        off_q <= off;
      end
      mem.mem_rd <= req && ok && rd_req ? 1'b1 : fin ? 1'b0 : mem.mem_rd;
      mem.mem_wr <= req && ok && !rd_req ? 1'b1 : fin ? 1'b0 : mem.mem_wr;
      mem.mem_be <= req && ok && !rd_req ? al_be : fin ? '0 : mem.mem_be;
      mem.mem_wdata <= req && ok && !rd_req ? al_wdata : mem.mem_wdata;
    end
  end
endmodule
